// File: rtl/jc_ctrl_pkg.sv
// Shared types and defaults for the Johnson-counter run controller.
package jc_ctrl_pkg;
  localparam int JC_WIDTH_DEF = 64;
  localparam int JC_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_SETLEN = 2'd1,
    OP_RUN    = 2'd2,
    OP_RSVD   = 2'd3
  } jc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } jc_state_e;
endpackage

// File: rtl/jc_step_core.sv
// Counter register and active length; performs one length-masked Johnson step.
module jc_step_core
  import jc_ctrl_pkg::*;
#(
  parameter int WIDTH = JC_WIDTH_DEF,
  parameter int CNT_W = JC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,
  input  logic             clear,
  input  logic             load_len,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] q_q, q_d, step_val;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] len_m1;
  logic             top_bit;

  assign len_m1  = len_q - 1'b1;
  assign top_bit = q_q[IW'(len_m1)];

  // Each bit picks its neighbour; the end bits of the active window take the
  // inverted opposite end, and anything outside the window is forced to 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic from_hi, from_lo, in_len, is_top;
    if (i == WIDTH - 1) begin : g_hi_edge
      assign from_hi = 1'b0;
    end else begin : g_hi
      assign from_hi = q_q[i+1];
    end
    if (i == 0) begin : g_lo_edge
      assign from_lo = ~top_bit;
    end else begin : g_lo
      assign from_lo = q_q[i-1];
    end
    assign in_len      = CNT_W'(i) < len_q;
    assign is_top      = CNT_W'(i) == len_m1;
    assign step_val[i] = in_len & (dir ? from_lo : (is_top ? ~q_q[0] : from_hi));
  end

  always_comb begin
    q_d   = q_q;
    len_d = len_q;
    if (load_len) begin
      len_d = len;
      q_d   = '0;
    end else if (clear) begin
      q_d = '0;
    end else if (step) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      len_q <= CNT_W'(WIDTH);
    end else begin
      q_q   <= q_d;
      len_q <= len_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/jc_run_ctrl.sv
// Command handshake, run FSM and step counter around the Johnson step core.
module jc_run_ctrl
  import jc_ctrl_pkg::*;
#(
  parameter int WIDTH = JC_WIDTH_DEF,
  parameter int CNT_W = JC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             cmd_dir,
  input  logic             step_en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [CNT_W-1:0] steps_left
);
  jc_state_e        state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d;
  logic             abrt_q, abrt_d;
  logic             err_q, err_d;
  logic             do_step, do_clear, do_load;
  logic             acc;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign acc       = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    dir_d    = dir_q;
    abrt_d   = abrt_q;
    err_d    = 1'b0;
    do_step  = 1'b0;
    do_clear = 1'b0;
    do_load  = 1'b0;
    case (state_q)
      ST_IDLE: if (acc) begin
        case (jc_op_e'(cmd_op))
          OP_CLEAR:  do_clear = 1'b1;
          OP_SETLEN: begin
            if (cmd_arg != '0 && cmd_arg <= CNT_W'(WIDTH)) do_load = 1'b1;
            else err_d = 1'b1;
          end
          OP_RUN: begin
            dir_d = cmd_dir;
            if (cmd_arg == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              steps_d = cmd_arg;
            end
          end
          default:   err_d = 1'b1;
        endcase
      end
      ST_RUN: begin
        // Abort wins over a step on the same edge.
        if (abort) begin
          state_d = ST_DONE;
          abrt_d  = 1'b1;
        end else if (step_en) begin
          do_step = 1'b1;
          steps_d = steps_q - 1'b1;
          if (steps_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        abrt_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      steps_q <= '0;
      dir_q   <= 1'b0;
      abrt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      abrt_q  <= abrt_d;
      err_q   <= err_d;
    end
  end

  jc_step_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .step     (do_step),
    .dir      (dir_q),
    .clear    (do_clear),
    .load_len (do_load),
    .len      (cmd_arg),
    .q        (q)
  );

  assign busy       = state_q != ST_IDLE;
  assign done       = state_q == ST_DONE;
  assign aborted    = done && abrt_q;
  assign err        = err_q;
  assign steps_left = steps_q;
endmodule

// File: tb/tb_jc_run_ctrl.sv
// Directed bench for jc_run_ctrl at WIDTH=8 with an expected-q scoreboard.
module tb_jc_run_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        cmd_dir;
  logic        step_en;
  logic        abort;
  logic [7:0]  q;
  logic        busy, done, aborted, err;
  logic [15:0] steps_left;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] m_q;
  int         m_len;
  logic [7:0] exp_q[$];

  jc_run_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_dir(cmd_dir), .step_en(step_en),
    .abort(abort), .q(q), .busy(busy), .done(done), .aborted(aborted),
    .err(err), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference step: shift the whole word, inject the inverted end bit, mask to L.
  function automatic logic [7:0] jref(input logic [7:0] cur, input int len, input bit dir);
    logic [8:0] mask, r;
    logic       b;
    mask = (9'd1 << len) - 9'd1;
    if (!dir) begin
      b = ~cur[0];
      r = {1'b0, cur >> 1} | ({8'd0, b} << (len - 1));
    end else begin
      b = ~cur[len-1];
      r = ({1'b0, cur} << 1) | {8'd0, b};
    end
    r = r & mask;
    return r[7:0];
  endfunction

  task automatic cmd(input logic [1:0] op, input int arg, input bit exp_err, input string tag);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = 16'(arg);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (op == 2'd0) m_q = '0;
    if (op == 2'd1 && !exp_err) begin m_len = arg; m_q = '0; end
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_q"}, q, m_q);
    @(negedge clk);
    chk({tag, "_err_clr"}, err, 0);
  endtask

  task automatic do_run(input int n, input bit dir, input bit tog, input int ab_k);
    int         edges, left;
    bit         saw_done, ab;
    logic [7:0] cur;
    exp_q.delete();
    cur = m_q;
    for (int i = 0; i < n; i++) begin
      cur = jref(cur, m_len, dir);
      exp_q.push_back(cur);
    end
    cur = m_q; left = n; edges = 0; saw_done = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 16'(n); cmd_dir = dir;
    step_en = 1'b1; abort = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (n == 0) begin
      chk("run0_done", done, 1);
      chk("run0_q", q, m_q);
    end else begin
      while (!saw_done && edges < 40) begin
        ab      = (ab_k == edges + 1);
        step_en = tog ? ((edges % 2) == 0) : 1'b1;
        abort   = ab;
        @(negedge clk);
        edges++;
        if (!ab && step_en && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          left--;
        end
        chk("run_q", q, cur);
        chk("run_left", steps_left, left);
        saw_done = done;
      end
      chk("run_edges", edges, (ab_k > 0) ? ab_k : (tog ? 2 * n - 1 : n));
      chk("run_done", done, 1);
      chk("run_aborted", aborted, ab_k > 0);
    end
    m_q = cur; step_en = 1'b0; abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_done_low", done, 0);
    chk("post_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; cmd_dir = 1'b0;
    step_en = 1'b0; abort = 1'b0;
    m_q = '0; m_len = 8;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_left", steps_left, 0);

    cmd(2'd1, 4, 1'b0, "setlen4");
    do_run(3, 1'b0, 1'b0, 0);
    chk("dir0_end", q, 8'h0E);
    cmd(2'd1, 4, 1'b0, "setlen4b");
    do_run(3, 1'b1, 1'b0, 0);
    chk("dir1_end", q, 8'h07);
    do_run(5, 1'b1, 1'b0, 0);
    chk("wrap_zero", q, 8'h00);

    do_run(6, 1'b0, 1'b1, 0);
    do_run(10, 1'b1, 1'b0, 2);
    chk("abort_left", steps_left, 9);

    cmd(2'd1, 0, 1'b1, "setlen0");
    cmd(2'd1, 9, 1'b1, "setlen9");
    cmd(2'd3, 5, 1'b1, "rsvd");
    do_run(0, 1'b0, 1'b0, 0);
    do_run(2, 1'b0, 1'b0, 0);
    cmd(2'd0, 0, 1'b0, "clear");
    cmd(2'd1, 1, 1'b0, "setlen1");
    do_run(3, 1'b0, 1'b0, 0);

    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 16'd10; cmd_dir = 1'b0; step_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_q", q, 0);
    chk("mrst_left", steps_left, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", cmd_ready, 0);
    rst = 1'b0; step_en = 1'b0;
    @(negedge clk);
    chk("mrst_no_done", done, 0);
    chk("mrst_ready_back", cmd_ready, 1);
    m_q = '0; m_len = 8;
    do_run(3, 1'b1, 1'b0, 0);
    chk("len_reset_8", q, 8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
